// File: rtl/avl_burst_pkg.sv
`default_nettype none
// avl_burst_pkg: shared state encoding, widths and sizing helper for avl_burst_writer.
// Revision 1.0
package avl_burst_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    BEAT = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int AVL_SIZE_W = 7;

  function automatic int words_for(input int buf_size, input int sample_w, input int data_w);
    return (buf_size * sample_w) / data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/avl_word_mux.sv
`default_nettype none
// avl_word_mux: combinational pick of one DATA_W word out of the flat buffer.
// Revision 1.0
module avl_word_mux #(
  parameter int DATA_W    = 128,
  parameter int NUM_WORDS = 64,
  parameter int IDX_W     = 7
) (
  input  logic [NUM_WORDS*DATA_W-1:0] buffer,
  input  logic [IDX_W-1:0]            index,
  output logic [DATA_W-1:0]           word
);

  localparam int SEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int SLOTS = 1 << SEL_W;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_WORDS);

  logic [DATA_W-1:0] words [SLOTS];

  // Pad up to a power of two so the select never addresses past the array.
  for (genvar w = 0; w < SLOTS; w++) begin : g_slot
    if (w < NUM_WORDS) begin : g_word
      assign words[w] = buffer[w*DATA_W +: DATA_W];
    end else begin : g_pad
      assign words[w] = '0;
    end
  end

  always_comb begin
    word = '0;
    if (index < IDX_END) word = words[index[SEL_W-1:0]];
  end

endmodule
`default_nettype wire

// File: rtl/avl_burst_writer.sv
`default_nettype none
// avl_burst_writer: streams a flat sample buffer into DDR3 as fixed-length Avalon-MM bursts.
// Revision 1.0
module avl_burst_writer
  import avl_burst_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int BUFFER_SIZE = 512,
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = 26,
  parameter int BURST_LEN   = 4
) (
  input  logic                            iCLK,
  input  logic                            iRST,
  input  logic                            start,
  input  logic                            abort,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [BUFFER_SIZE*SAMPLE_W-1:0] buffer,
  input  logic                            avl_waitrequest_n,
  output logic [ADDR_W-1:0]               avl_address,
  output logic [AVL_SIZE_W-1:0]           avl_size,
  output logic                            avl_burstbegin,
  output logic [DATA_W-1:0]               avl_writedata,
  output logic                            avl_write,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted
);

  localparam int NUM_WORDS = words_for(BUFFER_SIZE, SAMPLE_W, DATA_W);
  localparam int IDX_W     = $clog2(NUM_WORDS + 1);
  localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(NUM_WORDS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  if ((BUFFER_SIZE * SAMPLE_W) % DATA_W != 0) begin : g_chk_word_fit
    $error("buffer does not divide into whole DATA_W words");
  end
  if (BURST_LEN < 1 || BURST_LEN > 64) begin : g_chk_burst_range
    $error("BURST_LEN must be within 1..64");
  end
  if (NUM_WORDS % BURST_LEN != 0) begin : g_chk_burst_div
    $error("NUM_WORDS must be a multiple of BURST_LEN");
  end

  state_t             state;
  logic [ADDR_W-1:0]  base_q;
  logic [IDX_W-1:0]   index;
  logic [IDX_W-1:0]   sel_index;
  logic [BEAT_W-1:0]  beat_cnt;
  logic               abort_q;
  logic               accept;
  logic [DATA_W-1:0]  mux_word;
  logic [ADDR_W-1:0]  burst_addr;

  assign accept     = avl_write && avl_waitrequest_n;
  assign avl_size   = AVL_SIZE_W'(BURST_LEN);
  assign burst_addr = base_q + ADDR_W'(index);

  // On an accept the data register must already hold the following word next cycle.
  assign sel_index  = (state == BEAT && accept) ? index + IDX_W'(1) : index;

  avl_word_mux #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_word_mux (
    .buffer (buffer),
    .index  (sel_index),
    .word   (mux_word)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state          <= IDLE;
      base_q         <= '0;
      index          <= '0;
      beat_cnt       <= '0;
      abort_q        <= 1'b0;
      avl_address    <= '0;
      avl_writedata  <= '0;
      avl_burstbegin <= 1'b0;
      avl_write      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      // Abort is only remembered once a transfer is underway; bursts always run to the end.
      if (state != IDLE && state != DONE && abort) abort_q <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            base_q   <= base_addr;
            index    <= '0;
            abort_q  <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          avl_address    <= burst_addr;
          avl_writedata  <= mux_word;
          avl_burstbegin <= 1'b1;
          avl_write      <= 1'b1;
          beat_cnt       <= '0;
          state          <= BEAT;
        end

        BEAT: begin
          if (accept) begin
            avl_burstbegin <= 1'b0;
            avl_writedata  <= mux_word;
            index          <= index + IDX_W'(1);
            beat_cnt       <= beat_cnt + BEAT_W'(1);
            if (beat_cnt == BEAT_LAST) begin
              avl_write <= 1'b0;
              state     <= NEXT;
            end
          end
        end

        NEXT: begin
          if (index == IDX_END || abort_q || abort) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= abort_q || abort;
            state   <= DONE;
          end else begin
            state <= LOAD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avl_burst_writer.sv
`default_nettype none
// tb_avl_burst_writer: directed checks of burst sequencing, stalls, abort, wrap, restart and reset.
// Revision 1.0
module tb_avl_burst_writer;

  localparam int SAMPLE_W    = 16;
  localparam int BUFFER_SIZE = 512;
  localparam int DATA_W      = 128;
  localparam int ADDR_W      = 26;
  localparam int BURST_LEN   = 4;
  localparam int NWORDS      = 64;

  logic                            iCLK = 1'b0;
  logic                            iRST;
  logic                            start;
  logic                            abort;
  logic [ADDR_W-1:0]               base_addr;
  logic [BUFFER_SIZE*SAMPLE_W-1:0] buffer;
  logic                            avl_waitrequest_n;
  logic [ADDR_W-1:0]               avl_address;
  logic [6:0]                      avl_size;
  logic                            avl_burstbegin;
  logic [DATA_W-1:0]               avl_writedata;
  logic                            avl_write;
  logic                            busy;
  logic                            done;
  logic                            aborted;

  avl_burst_writer #(
    .SAMPLE_W    (SAMPLE_W),
    .BUFFER_SIZE (BUFFER_SIZE),
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN)
  ) dut (
    .iCLK              (iCLK),
    .iRST              (iRST),
    .start             (start),
    .abort             (abort),
    .base_addr         (base_addr),
    .buffer            (buffer),
    .avl_waitrequest_n (avl_waitrequest_n),
    .avl_address       (avl_address),
    .avl_size          (avl_size),
    .avl_burstbegin    (avl_burstbegin),
    .avl_writedata     (avl_writedata),
    .avl_write         (avl_write),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted)
  );

  always #5 iCLK = ~iCLK;

  int vectors    = 0;
  int miscompares = 0;
  int k;          // accepted beats in the current transfer == expected word index
  int cyc_n;      // negedges since the start pulse was set up
  int first_wr;
  int done_at;
  logic              rand_wait = 1'b0;
  logic [ADDR_W-1:0] cur_base  = '0;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  logic              prev_bb;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input int kk);
    return cur_base + ADDR_W'((kk / BURST_LEN) * BURST_LEN);
  endfunction

  function automatic logic [DATA_W-1:0] exp_word(input int kk);
    logic [15:0] s;
    s = 16'(kk);
    return {8{s}};
  endfunction

  // One clock: drive waitrequest for the coming edge, then score what the DUT presents.
  task automatic cyc();
    @(negedge iCLK);
    avl_waitrequest_n = rand_wait ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc_n++;
    if (prev_stall) begin
      check("hold_write", avl_write, 1'b1);
      check("hold_addr", avl_address, prev_addr);
      check("hold_data", avl_writedata, prev_data);
      check("hold_bb", avl_burstbegin, prev_bb);
    end
    if (avl_write && first_wr < 0) first_wr = cyc_n;
    if (avl_write && avl_waitrequest_n) begin
      check("beat_addr", avl_address, exp_addr(k));
      check("beat_data", avl_writedata, exp_word(k));
      check("beat_bb", avl_burstbegin, (k % BURST_LEN) == 0);
      k++;
    end
    prev_stall = avl_write && !avl_waitrequest_n;
    prev_addr  = avl_address;
    prev_data  = avl_writedata;
    prev_bb    = avl_burstbegin;
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] b);
    start     = 1'b1;
    base_addr = b;
    cur_base  = b;
    k         = 0;
    cyc_n     = 0;
    first_wr  = -1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (done) begin
        at = cyc_n;
        break;
      end
    end
    if (at < 0) check("done_timeout", done, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_write"}, avl_write, 1'b0);
    check({tag, "_bb"}, avl_burstbegin, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_aborted"}, aborted, 1'b0);
    check({tag, "_addr"}, avl_address, 26'h0);
    check({tag, "_data"}, avl_writedata, 128'h0);
  endtask

  initial begin
    logic sent;
    iRST = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    avl_waitrequest_n = 1'b1;
    for (int w = 0; w < NWORDS; w++) buffer[w*DATA_W +: DATA_W] = exp_word(w);
    k = 0;
    cyc_n = 0;
    first_wr = -1;

    // Reset state
    repeat (2) @(negedge iCLK);
    check_reset_values("reset");
    check("avl_size", avl_size, 7'd4);
    iRST = 1'b0;
    cyc();

    // Full transfer, no wait states, base 0x100
    start_xfer(26'h100);
    check("busy_after_start", busy, 1'b1);
    check("done_after_start", done, 1'b0);
    wait_done(done_at);
    // Start edge + 16 bursts of LOAD/4xBEAT/NEXT: done visible 97 negedges after the start setup.
    check("first_write_cycle", first_wr, 2);
    check("done_cycle", done_at, 97);
    check("plain_beats", k, NWORDS);
    check("plain_aborted", aborted, 1'b0);
    check("plain_busy", busy, 1'b0);
    repeat (6) cyc();
    check("plain_quiet_beats", k, NWORDS);
    check("plain_done_level", done, 1'b1);

    // Random wait states, base 0x200
    rand_wait = 1'b1;
    start_xfer(26'h200);
    wait_done(done_at);
    rand_wait = 1'b0;
    check("rand_beats", k, NWORDS);
    check("rand_aborted", aborted, 1'b0);

    // Abort during beat 2 of the fourth burst
    start_xfer(26'h0);
    sent = 1'b0;
    done_at = -1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      abort = 1'b0;
      if (k == 15 && !sent) begin
        abort = 1'b1;
        sent = 1'b1;
      end
      if (done) begin
        done_at = cyc_n;
        break;
      end
    end
    abort = 1'b0;
    check("abort_done", done, 1'b1);
    check("abort_flag", aborted, 1'b1);
    check("abort_beats", k, 16);
    repeat (8) cyc();
    check("abort_quiet_beats", k, 16);
    check("abort_no_write", avl_write, 1'b0);

    // Address wrap near the top of the address space
    start_xfer(26'h3FFFFF8);
    wait_done(done_at);
    check("wrap_beats", k, NWORDS);
    check("wrap_last_addr", avl_address, 26'h000003C - 26'h8);

    // Start while busy is ignored
    start_xfer(26'h300);
    for (int i = 0; i < 200 && k < 20; i++) cyc();
    start = 1'b1;
    base_addr = 26'h3AB;
    cyc();
    start = 1'b0;
    wait_done(done_at);
    check("busy_start_beats", k, NWORDS);
    check("busy_start_aborted", aborted, 1'b0);

    // Start while done restarts; done clears on the next cycle
    start_xfer(26'h300);
    check("restart_done_clear", done, 1'b0);
    check("restart_busy", busy, 1'b1);
    wait_done(done_at);
    check("restart_beats", k, NWORDS);

    // Asynchronous reset in the middle of a burst
    start_xfer(26'h80);
    for (int i = 0; i < 200 && k < 6; i++) cyc();
    check("pre_reset_write", avl_write, 1'b1);
    iRST = 1'b1;
    #1;
    check_reset_values("async_reset");
    prev_stall = 1'b0;
    cyc();
    cyc();
    iRST = 1'b0;
    cyc();
    start_xfer(26'h40);
    wait_done(done_at);
    check("post_reset_beats", k, NWORDS);
    check("post_reset_aborted", aborted, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
